// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one multi-cycle signed divider among NUM_REQ requesters.
// Round-robin arbitration in IDLE, operand hold while the divider runs, result
// capture on div_done and a one-hot, single-cycle response pulse to the winner.
// The arbiter does no arithmetic itself; operands and results pass bit-exact.
//
// Build option: define DIV_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, round-robin pointer unused). Default build is round-robin.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req/req_dividend/req_divisor  per-requester request level and packed operands
//   resp_valid                 one-hot response pulse
//   resp_quotient/remainder/overflow  shared result bus, held until next capture
//   busy, grant_id             FSM not idle; current/last granted requester
//   div_start/div_dividend/div_divisor  divider command side (registered)
//   div_quotient/remainder/overflow/done  divider result side
module divider_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DIVIDEND_WIDTH = 32,
  parameter int unsigned DIVISOR_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]    req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]     req_divisor,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [DIVIDEND_WIDTH-1:0]            resp_quotient,
  output logic [DIVISOR_WIDTH-1:0]             resp_remainder,
  output logic                                 resp_overflow,
  output logic                                 busy,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 div_start,
  output logic [DIVIDEND_WIDTH-1:0]            div_dividend,
  output logic [DIVISOR_WIDTH-1:0]             div_divisor,
  input  logic [DIVIDEND_WIDTH-1:0]            div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]             div_remainder,
  input  logic                                 div_overflow,
  input  logic                                 div_done
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [ID_W-1:0]           last_q, last_d;
  logic [ID_W-1:0]           grant_d;
  logic                      start_d;
  logic                      busy_d;
  logic [DIVIDEND_WIDTH-1:0] dividend_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_d;
  logic [NUM_REQ-1:0]        resp_valid_d;
  logic [DIVIDEND_WIDTH-1:0] quot_d;
  logic [DIVISOR_WIDTH-1:0]  rem_d;
  logic                      ovf_d;

  logic [ID_W-1:0]           win_c;
  logic [DIVIDEND_WIDTH-1:0] win_dividend_c;
  logic [DIVISOR_WIDTH-1:0]  win_divisor_c;

  // Winner selection; only consumed in IDLE when |req.
`ifdef DIV_ARB_FIXED_PRIO_EN
  always_comb begin
    win_c = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) win_c = ID_W'(i);
    end
  end
`else
  // Lowest requester overall is the wrap-around fallback; the second pass
  // overrides it with the lowest requester strictly above the last grant.
  always_comb begin
    win_c = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) win_c = ID_W'(i);
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) > last_q)) win_c = ID_W'(i);
    end
  end
`endif

  // Operand mux for the selected requester.
  always_comb begin
    win_dividend_c = '0;
    win_divisor_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_c) begin
        win_dividend_c = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        win_divisor_c  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_id;
    start_d      = 1'b0;
    dividend_d   = div_dividend;
    divisor_d    = div_divisor;
    resp_valid_d = '0;
    quot_d       = resp_quotient;
    rem_d        = resp_remainder;
    ovf_d        = resp_overflow;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_ISSUE;
          grant_d    = win_c;
          last_d     = win_c;
          dividend_d = win_dividend_c;
          divisor_d  = win_divisor_c;
          start_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done) begin
          state_d      = ST_RESP;
          quot_d       = div_quotient;
          rem_d        = div_remainder;
          ovf_d        = div_overflow;
          resp_valid_d = NUM_REQ'(1) << grant_id;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      last_q         <= ID_W'(NUM_REQ - 1);
      grant_id       <= '0;
      div_start      <= 1'b0;
      div_dividend   <= '0;
      div_divisor    <= '0;
      resp_valid     <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_overflow  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      grant_id       <= grant_d;
      div_start      <= start_d;
      div_dividend   <= dividend_d;
      div_divisor    <= divisor_d;
      resp_valid     <= resp_valid_d;
      resp_quotient  <= quot_d;
      resp_remainder <= rem_d;
      resp_overflow  <= ovf_d;
      busy           <= busy_d;
    end
  end

endmodule
